// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared helpers for the elastic pipeline register.
// The per-stage record (valid bit plus data) depends on WIDTH, so it is
// declared inside pipe_reg_stage where WIDTH is known.
package pipe_reg_pkg;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one pipeline slot holding a valid bit and a data word.
// load wins over clear; clear only drops the valid bit and leaves the data,
// since data in an empty slot is never looked at downstream.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_rec_t;

  stage_rec_t stage_q;
  stage_rec_t stage_d;

  // Next slot contents: take new data on load, otherwise optionally empty it.
  always_comb begin
    stage_d = stage_q;
    if (load) begin
      stage_d.valid = 1'b1;
      stage_d.data  = load_data;
    end else if (clear) begin
      stage_d.valid = 1'b0;
    end
  end

  // Slot register; reset empties the slot and restores the init word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q.valid <= 1'b0;
      stage_q.data  <= INIT;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid = stage_q.valid;
  assign data  = stage_q.data;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: WIDTH x DEPTH elastic pipeline register with valid/ready
// handshake, bubble collapsing, global enable and synchronous flush.
// Optional feature macro: PIPE_REG_OCC_EN adds the registered occupancy port.
// Note: in_ready is combinational from out_ready through the move chain, so
// callers must not feed in_ready back into out_ready.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
`ifdef PIPE_REG_OCC_EN
  output logic [occ_width(DEPTH)-1:0]  occupancy,
`endif
  input  logic                         out_ready
);

  logic                        active;
  logic                        head_free;
  logic                        accept;
  logic [DEPTH-1:0]            move;
  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH-1:0]            stage_load;
  logic [DEPTH-1:0]            stage_clear;
  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0][WIDTH-1:0] stage_load_data;

  assign active = en & ~flush;

  // Move chain, walked from the output side back to the input side: a stage
  // advances when it holds data and the slot ahead is empty or itself moving.
  always_comb begin
    logic go;
    move = '0;
    go   = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      move[i] = active & stage_valid[i] & go;
      go      = ~stage_valid[i] | move[i];
    end
    head_free = go;
  end

  assign in_ready  = active & ~rst & head_free;
  assign accept    = in_valid & in_ready;
  assign out_valid = active & stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  // Per-stage load/clear: each slot loads from its upstream neighbour (or the
  // producer) and empties when its own item leaves; flush empties them all.
  always_comb begin
    stage_load         = '0;
    stage_clear        = '0;
    stage_load_data    = '0;
    stage_load[0]      = accept;
    stage_load_data[0] = in_data;
    stage_clear[0]     = flush | move[0];
    for (int i = 1; i < DEPTH; i++) begin
      stage_load[i]      = move[i-1];
      stage_load_data[i] = stage_data[i-1];
      stage_clear[i]     = flush | move[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_reg_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load      (stage_load[g]),
      .clear     (stage_clear[g]),
      .load_data (stage_load_data[g]),
      .valid     (stage_valid[g]),
      .data      (stage_data[g])
    );
  end

`ifdef PIPE_REG_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic             drain;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  assign drain = move[DEPTH-1];

  // Item count: up on accept alone, down on drain alone, zero on flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept & ~drain) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (drain & ~accept) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifndef SYNTHESIS
  a_occ_matches_valid : assert property (@(posedge clk) disable iff (rst)
    occ_q == OCC_W'($countones(stage_valid)));
`endif
`else
  // No occupancy counter in this build; the pipeline itself is unchanged.
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed, table-driven bench for pipe_reg (WIDTH=8, DEPTH=3,
// INIT=0xA5). Inputs change 1 time unit after a rising edge and outputs are
// compared 1 unit later, well clear of the next edge.
module tb_pipe_reg;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] INIT  = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef PIPE_REG_OCC_EN
  logic [1:0]       occupancy;
`endif

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    string      tag;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic       chk_data;
    logic [7:0] exp_out_data;
    int         exp_occ;
  } vec_t;

  vec_t vecs[$];

  pipe_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef PIPE_REG_OCC_EN
    .occupancy (occupancy),
`endif
    .out_ready (out_ready)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drive all inputs together and let combinational outputs settle.
  task automatic applyStimulus(input logic e, input logic f, input logic iv,
                               input logic [7:0] d, input logic orr);
    en        = e;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    #1;
  endtask

  task automatic checkOcc(input string name, input int expected);
`ifdef PIPE_REG_OCC_EN
    checkOutput(name, int'(occupancy), expected);
`endif
  endtask

  function automatic vec_t mk(input string tag, input logic e, input logic f,
                              input logic iv, input logic [7:0] d, input logic orr,
                              input logic xr, input logic xv, input logic cd,
                              input logic [7:0] xd, input int occ);
    vec_t v;
    v.tag = tag; v.en = e; v.flush = f; v.in_valid = iv; v.in_data = d;
    v.out_ready = orr; v.exp_in_ready = xr; v.exp_out_valid = xv;
    v.chk_data = cd; v.exp_out_data = xd; v.exp_occ = occ;
    return v;
  endfunction

  // Apply each queued vector for one cycle, compare, then clock it in.
  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].flush, vecs[i].in_valid,
                    vecs[i].in_data, vecs[i].out_ready);
      checkOutput($sformatf("in_ready[%s]", vecs[i].tag), int'(in_ready),
                  int'(vecs[i].exp_in_ready));
      checkOutput($sformatf("out_valid[%s]", vecs[i].tag), int'(out_valid),
                  int'(vecs[i].exp_out_valid));
      if (vecs[i].chk_data)
        checkOutput($sformatf("out_data[%s]", vecs[i].tag), int'(out_data),
                    int'(vecs[i].exp_out_data));
      checkOcc($sformatf("occupancy[%s]", vecs[i].tag), vecs[i].exp_occ);
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  initial begin
    // Reset state, with a producer already offering data.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    #1;
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_data", int'(out_data), int'(INIT));
    checkOcc("reset occupancy", 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming 0x01..0x10 with out_ready=1: item k leaves in cycle k+3.
    for (int k = 0; k < 20; k++) begin
      int occ;
      logic xv;
      logic [7:0] xd;
      occ = ((k < 16) ? k : 16) - ((k < 3) ? 0 : ((k - 3 < 16) ? k - 3 : 16));
      xv  = (k >= 3) && (k <= 18);
      xd  = (k < 3) ? INIT : 8'(k - 2);
      vecs.push_back(mk($sformatf("stream%0d", k), 1, 0, (k < 16), 8'(k + 1), 1,
                        1, xv, (k <= 18), xd, occ));
    end
    runVectors();

    // Backpressure: fourth item refused while full, then all drain in order.
    vecs.push_back(mk("bp0", 1, 0, 1, 8'h11, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk("bp1", 1, 0, 1, 8'h22, 0, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk("bp2", 1, 0, 1, 8'h33, 0, 1, 0, 0, 8'h00, 2));
    vecs.push_back(mk("bp3", 1, 0, 1, 8'h44, 0, 0, 1, 1, 8'h11, 3));
    vecs.push_back(mk("bp4", 1, 0, 1, 8'h44, 1, 1, 1, 1, 8'h11, 3));
    vecs.push_back(mk("bp5", 1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h22, 3));
    vecs.push_back(mk("bp6", 1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h33, 2));
    vecs.push_back(mk("bp7", 1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h44, 1));
    vecs.push_back(mk("bp8", 1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
    runVectors();

    // Bubble collapse (items at stages 0 and 2), then flush with 3 held.
    vecs.push_back(mk("bb0", 1, 0, 1, 8'h5A, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk("bb1", 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk("bb2", 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk("bb3", 1, 0, 1, 8'h6B, 0, 1, 1, 1, 8'h5A, 1));
    vecs.push_back(mk("bb4", 1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h5A, 2));
    vecs.push_back(mk("bb5", 1, 0, 1, 8'h7C, 0, 1, 1, 1, 8'h5A, 2));
    vecs.push_back(mk("bb6", 1, 0, 1, 8'h8D, 0, 0, 1, 1, 8'h5A, 3));
    vecs.push_back(mk("flush", 1, 1, 1, 8'h8D, 1, 0, 0, 1, 8'h5A, 3));
    vecs.push_back(mk("postflush", 1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
    runVectors();

    // Enable: two items held, en=0 for 5 cycles, then resume.
    vecs.push_back(mk("en0", 1, 0, 1, 8'h21, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk("en1", 1, 0, 1, 8'h32, 0, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk("en2", 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk($sformatf("frozen%0d", k), 0, 0, 1, 8'h54, 1, 0, 0, 1, 8'h21, 2));
    vecs.push_back(mk("resume", 1, 0, 1, 8'h54, 1, 1, 1, 1, 8'h21, 2));
    vecs.push_back(mk("en9", 1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h32, 2));
    vecs.push_back(mk("en10", 1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk("en11", 1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h54, 1));
    vecs.push_back(mk("en12", 1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
    runVectors();

    // Mid-stream reset: fill to the output stage, then reset mid-cycle.
    vecs.push_back(mk("rs0", 1, 0, 1, 8'h99, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk("rs1", 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk("rs2", 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1));
    runVectors();
    #1;
    checkOutput("prereset out_valid", int'(out_valid), 1);
    checkOutput("prereset out_data", int'(out_data), 'h99);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset out_valid", int'(out_valid), 0);
    checkOutput("midreset out_data", int'(out_data), int'(INIT));
    checkOutput("midreset in_ready", int'(in_ready), 0);
    checkOcc("midreset occupancy", 0);

    // Release reset and accept on the very first edge after it.
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    checkOutput("release in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("release lat1 out_valid", int'(out_valid), 0);
    @(posedge clk);
    #2;
    checkOutput("release lat2 out_valid", int'(out_valid), 0);
    @(posedge clk);
    #2;
    checkOutput("release lat3 out_valid", int'(out_valid), 1);
    checkOutput("release lat3 out_data", int'(out_data), 'h77);
    @(posedge clk);
    #2;
    checkOutput("release drained out_valid", int'(out_valid), 0);
    checkOcc("release drained occupancy", 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
